// File: rtl/mult4u_residue_checker_pkg.sv
// Shared types, widths and the mod-3 residue helper for the residue-checked
// 4x4 multiplier wrapper.
package mult4u_pkg;

    localparam int A_W = 4;
    localparam int B_W = 4;
    localparam int P_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        OUT
    } chk_state_t;

    // Each 2-bit group has weight 4^k == 1 (mod 3), so summing the groups
    // and folding the sum again preserves the residue.
    function automatic logic [1:0] mod3(input logic [P_W-1:0] value);
        logic [3:0] sum1;
        logic [2:0] sum2;
        logic [1:0] sum3;
        sum1 = 4'(value[1:0]) + 4'(value[3:2]) + 4'(value[5:4]) + 4'(value[7:6]);
        sum2 = 3'(sum1[1:0]) + 3'(sum1[3:2]);
        sum3 = sum2[1:0] + 2'(sum2[2]);
        return (sum3 == 2'd3) ? 2'd0 : sum3;
    endfunction

endpackage

// File: rtl/mult4u_residue_checker_if.sv
// Operand/result handshake and multiplier-side bus of the residue checker.
interface mult4u_residue_checker_if;
    import mult4u_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic [A_W-1:0] mul_a;
    logic [B_W-1:0] mul_b;
    logic [P_W-1:0] mul_p;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] out_p;
    logic           out_err;
    logic [3:0]     out_retries;

    modport slave (
        input  in_valid, in_a, in_b, mul_p, out_ready,
        output in_ready, mul_a, mul_b, out_valid, out_p, out_err, out_retries
    );

    modport master (
        output in_valid, in_a, in_b, mul_p, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, out_p, out_err, out_retries
    );

endinterface

// File: rtl/mult4u_residue_checker_mod3_residue.sv
// Combinational mod-3 residue of an unsigned value up to 8 bits wide.
module mod3_residue
    import mult4u_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    output logic [1:0]   residue
);

    assign residue = mod3(P_W'(value));

endmodule

// File: rtl/mult4u_residue_checker.sv
// Sequential wrapper around an external 4x4 multiplier: registers operands,
// waits for the product to settle, checks it mod 3 and re-samples on mismatch.
module mult4u_residue_checker
    import mult4u_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int MAX_RETRY     = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult4u_residue_checker_if.slave bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      RETRY_MAX   = 4'(MAX_RETRY);

    chk_state_t      state;
    logic [SC_W-1:0] settle_cnt;
    logic [3:0]      retry_cnt;

    logic [1:0] res_a;
    logic [1:0] res_b;
    logic [3:0] res_prod;
    logic [1:0] res_exp;
    logic [1:0] res_got;

    mod3_residue #(.W(A_W)) u_res_a    (.value(bus.mul_a), .residue(res_a));
    mod3_residue #(.W(B_W)) u_res_b    (.value(bus.mul_b), .residue(res_b));
    mod3_residue #(.W(4))   u_res_prod (.value(res_prod),  .residue(res_exp));
    mod3_residue #(.W(P_W)) u_res_p    (.value(bus.mul_p), .residue(res_got));

    assign res_prod = {2'b00, res_a} * {2'b00, res_b};

    // NOTE: every register below is state, so it is assigned with <= only;
    // in_ready is registered and therefore rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            retry_cnt       <= '0;
            bus.in_ready    <= 1'b0;
            bus.mul_a       <= '0;
            bus.mul_b       <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_p       <= '0;
            bus.out_err     <= 1'b0;
            bus.out_retries <= '0;
            err_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        bus.mul_a    <= bus.in_a;
                        bus.mul_b    <= bus.in_b;
                        retry_cnt    <= '0;
                        settle_cnt   <= SETTLE_LOAD;
                        bus.in_ready <= 1'b0;
                        state        <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (res_got == res_exp) begin
                        bus.out_p       <= bus.mul_p;
                        bus.out_err     <= 1'b0;
                        bus.out_retries <= retry_cnt;
                        bus.out_valid   <= 1'b1;
                        state           <= OUT;
                    end else if (retry_cnt < RETRY_MAX) begin
                        retry_cnt  <= retry_cnt + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end else begin
                        bus.out_p       <= bus.mul_p;
                        bus.out_err     <= 1'b1;
                        bus.out_retries <= retry_cnt;
                        bus.out_valid   <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        state <= OUT;
                    end
                end
                OUT: begin
                    // in_ready stays low through the handshake edge: no back-to-back accept.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult4u_residue_checker.sv
// Scoreboard bench for mult4u_residue_checker with a scripted faulty multiplier.
module tb_mult4u_residue_checker;
    import mult4u_pkg::*;

    localparam int S   = 1;
    localparam int MR  = 2;
    localparam int ECW = 8;

    typedef struct {
        logic [7:0] p;
        logic       err;
        logic [3:0] retries;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult4u_residue_checker_if bus();
    logic [ECW-1:0] err_cnt;

    logic       fault_on = 1'b0;
    logic [7:0] fault_p  = 8'd0;
    assign bus.mul_p = fault_on ? fault_p : ({4'b0000, bus.mul_a} * {4'b0000, bus.mul_b});

    mult4u_residue_checker #(
        .SETTLE_CYCLES(S),
        .MAX_RETRY    (MR),
        .ERR_CNT_W    (ECW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .err_cnt(err_cnt)
    );

    exp_t           sb[$];
    int             tests_run = 0;
    int             fails = 0;
    logic [ECW-1:0] exp_cnt = '0;

    // One operation: push expectation, drive operands, play the multiplier
    // (bad value for the first n_bad samples), then check and handshake.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] bad, input int n_bad,
                          input logic [7:0] exp_p, input logic exp_err,
                          input logic [3:0] exp_ret, input int hold, input bit poke);
        exp_t x;
        int   e;
        int   samples;
        x.p = exp_p; x.err = exp_err; x.retries = exp_ret;
        x.lat = S + 2 + int'(exp_ret) * (S + 1);
        sb.push_back(x);

        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        fault_p = bad; fault_on = (n_bad > 0);
        tests_run++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL in_ready_idle: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        e = 1; samples = 0;
        tests_run++;
        if ({bus.mul_a, bus.mul_b} !== {a, b}) begin fails++; $display("FAIL operand_latch: got %h%h want %h%h", bus.mul_a, bus.mul_b, a, b); end

        while (bus.out_valid !== 1'b1 && e < 64) begin
            if (e == 1 + (S + 1) * (samples + 1)) begin
                samples++;
                if (samples >= n_bad) fault_on = 1'b0;
            end
            @(posedge clk); #1;
            e++;
        end
        fault_on = 1'b0;
        x = sb.pop_front();
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            fails++; $display("FAIL out_valid_timeout: no result after %0d edges, want edge %0d", e, x.lat);
            return;
        end
        if (x.err && exp_cnt != '1) exp_cnt++;

        if (e !== x.lat) begin fails++; $display("FAIL latency: got edge %0d want edge %0d", e, x.lat); end
        tests_run++;
        if (bus.out_p !== x.p) begin fails++; $display("FAIL out_p: got %0d want %0d", bus.out_p, x.p); end
        tests_run++;
        if (bus.out_err !== x.err) begin fails++; $display("FAIL out_err: got %b want %b", bus.out_err, x.err); end
        tests_run++;
        if (bus.out_retries !== x.retries) begin fails++; $display("FAIL out_retries: got %0d want %0d", bus.out_retries, x.retries); end
        tests_run++;
        if (err_cnt !== exp_cnt) begin fails++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_cnt); end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (poke && i == 1) begin
                bus.in_a = ~a; bus.in_b = ~b; bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tests_run++;
            if ({bus.out_valid, bus.out_p, bus.out_err, bus.in_ready} !== {1'b1, x.p, x.err, 1'b0}) begin
                fails++;
                $display("FAIL backpressure_hold: got v=%b p=%0d e=%b rdy=%b want v=1 p=%0d e=%b rdy=0",
                         bus.out_valid, bus.out_p, bus.out_err, bus.in_ready, x.p, x.err);
            end
        end

        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = poke;
        bus.in_a = ~a; bus.in_b = ~b;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        tests_run++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            fails++; $display("FAIL handshake: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        if (poke) begin
            @(posedge clk); #1;
            tests_run++;
            if ({bus.mul_a, bus.mul_b, bus.in_ready} !== {a, b, 1'b1}) begin
                fails++; $display("FAIL busy_in_valid_ignored: got %h%h rdy=%b want %h%h rdy=1",
                                  bus.mul_a, bus.mul_b, bus.in_ready, a, b);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if ({bus.in_ready, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_p, bus.out_err, bus.out_retries, err_cnt} !== '0) begin
            fails++; $display("FAIL reset_values: got rdy=%b a=%0d b=%0d v=%b p=%0d e=%b r=%0d cnt=%0d want all 0",
                              bus.in_ready, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_p, bus.out_err, bus.out_retries, err_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL in_ready_after_reset: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        run_op(4'd13, 4'd11, 8'd0, 0, 8'd143, 1'b0, 4'd0, 0, 1'b0);
    endtask

    task automatic test_transient();
        run_op(4'd13, 4'd11, 8'd142, 1, 8'd143, 1'b0, 4'd1, 0, 1'b0);
    endtask

    task automatic test_persistent();
        run_op(4'd13, 4'd11, 8'd142, 99, 8'd142, 1'b1, 4'd2, 0, 1'b0);
    endtask

    task automatic test_alias();
        run_op(4'd13, 4'd11, 8'd146, 99, 8'd146, 1'b0, 4'd0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [3:0] b;
        run_op(4'd0, 4'd0, 8'd0, 0, 8'd0, 1'b0, 4'd0, 0, 1'b0);
        run_op(4'd15, 4'd15, 8'd0, 0, 8'd225, 1'b0, 4'd0, 0, 1'b0);
        run_op(4'd15, 4'd0, 8'd0, 0, 8'd0, 1'b0, 4'd0, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            run_op(a, b, 8'd0, 0, 8'(int'(a) * int'(b)), 1'b0, 4'd0, 0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        run_op(4'd7, 4'd9, 8'd62, 99, 8'd62, 1'b1, 4'd2, 4, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(4'd5, 4'd6, 8'd0, 0, 8'd30, 1'b0, 4'd0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_settle();
        @(negedge clk);
        bus.in_a = 4'd9; bus.in_b = 4'd3; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.in_ready, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_p, bus.out_err, bus.out_retries, err_cnt} !== '0) begin
            fails++; $display("FAIL reset_mid_settle: got rdy=%b a=%0d b=%0d v=%b p=%0d e=%b r=%0d cnt=%0d want all 0",
                              bus.in_ready, bus.mul_a, bus.mul_b, bus.out_valid, bus.out_p, bus.out_err, bus.out_retries, err_cnt);
        end
        exp_cnt = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            fails++; $display("FAIL after_mid_reset: got rdy=%b v=%b want rdy=1 v=0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 256; i++) begin
            run_op(4'd13, 4'd11, 8'd142, 99, 8'd142, 1'b1, 4'd2, 0, 1'b0);
        end
        tests_run++;
        if (err_cnt !== 8'd255) begin fails++; $display("FAIL err_cnt_saturate: got %0d want 255", err_cnt); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_transient();
        test_persistent();
        test_alias();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_settle();
        test_err_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit after %0d tests", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
